// File: rtl/rs_15_11_encoder_if.sv
// rs_15_11_encoder_if: message-in / codeword-out symbol streams of the RS(15,11) encoder.
`default_nettype none

interface rs_15_11_encoder_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

`default_nettype wire

// File: rtl/rs_15_11_encoder.sv
// ============================================================================
// Module : rs_15_11_encoder
// Brief  : Systematic RS(15,11) encoder over GF(16); optional RS_ERR_INJECT_EN
//          adds a per-codeword single-symbol error injector on the output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_15_11_encoder (
  input  wire logic       CLK,
  input  wire logic       RST_N,
`ifdef RS_ERR_INJECT_EN
  input  wire logic       ERR_EN,
  input  wire logic [3:0] ERR_POS,
  input  wire logic [3:0] ERR_MASK,
`endif
  rs_15_11_encoder_if.slave bus
);

  localparam logic [3:0] c_G3    = 4'd15;
  localparam logic [3:0] c_G2    = 4'd3;
  localparam logic [3:0] c_G1    = 4'd1;
  localparam logic [3:0] c_G0    = 4'd12;
  localparam logic [3:0] c_K_LST = 4'd10;

  typedef enum logic [0:0] {
    S_MSG    = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  // Multiply modulo x^4 + x + 1 (x^4 folds back to x + 1).
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_pcnt;
  logic [3:0] r_par0, r_par1, r_par2, r_par3;
  logic       r_out_valid;
  logic [3:0] r_out_data;
  logic       r_out_last;

  logic       w_adv;
  logic       w_in_ready;
  logic       w_in_fire;
  logic [3:0] w_fb;
  logic [3:0] w_corrupt;

  assign w_adv      = !r_out_valid || bus.out_ready;
  assign w_in_ready = RST_N && (r_state == S_MSG) && w_adv;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_fb       = bus.in_data ^ r_par3;

`ifdef RS_ERR_INJECT_EN
  logic       r_err_en;
  logic [3:0] r_err_pos;
  logic [3:0] r_err_mask;
  logic       w_first;
  logic       w_err_en;
  logic [3:0] w_err_pos;
  logic [3:0] w_err_mask;
  logic [3:0] w_idx;

  // Controls are live on the codeword's first symbol, then come from the capture.
  assign w_first    = (r_state == S_MSG) && (r_cnt == 4'd0);
  assign w_err_en   = w_first ? ERR_EN   : r_err_en;
  assign w_err_pos  = w_first ? ERR_POS  : r_err_pos;
  assign w_err_mask = w_first ? ERR_MASK : r_err_mask;
  assign w_idx      = (r_state == S_MSG) ? r_cnt : (4'd11 + {2'b00, r_pcnt});
  assign w_corrupt  = (w_err_en && (w_err_pos == w_idx)) ? w_err_mask : 4'h0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err_en   <= 1'b0;
      r_err_pos  <= 4'h0;
      r_err_mask <= 4'h0;
    end else if (w_in_fire && w_first) begin
      r_err_en   <= ERR_EN;
      r_err_pos  <= ERR_POS;
      r_err_mask <= ERR_MASK;
    end
  end
`else
  assign w_corrupt = 4'h0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_MSG;
      r_cnt       <= 4'd0;
      r_pcnt      <= 2'd0;
      r_par0      <= 4'h0;
      r_par1      <= 4'h0;
      r_par2      <= 4'h0;
      r_par3      <= 4'h0;
      r_out_valid <= 1'b0;
      r_out_data  <= 4'h0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_MSG: begin
          if (w_in_fire) begin
            r_out_data  <= bus.in_data ^ w_corrupt;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            // LFSR always divides the clean message, never the injected copy.
            r_par3      <= r_par2 ^ gf_mul(w_fb, c_G3);
            r_par2      <= r_par1 ^ gf_mul(w_fb, c_G2);
            r_par1      <= r_par0 ^ gf_mul(w_fb, c_G1);
            r_par0      <= gf_mul(w_fb, c_G0);
            if (r_cnt == c_K_LST) begin
              r_cnt   <= 4'd0;
              r_state <= S_PARITY;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else if (w_adv) begin
            r_out_valid <= 1'b0;
          end
        end
        S_PARITY: begin
          if (w_adv) begin
            r_out_data  <= r_par3 ^ w_corrupt;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_pcnt == 2'd3);
            r_par3      <= r_par2;
            r_par2      <= r_par1;
            r_par1      <= r_par0;
            r_par0      <= 4'h0;
            if (r_pcnt == 2'd3) begin
              r_pcnt  <= 2'd0;
              r_state <= S_MSG;
            end else begin
              r_pcnt <= r_pcnt + 2'd1;
            end
          end
        end
        default: r_state <= S_MSG;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

endmodule

`default_nettype wire
